// File: rtl/mvm_pkg.sv
// Shared types and helpers for the mvm_engine matrix-vector multiplier.
// Define MVM_SIGNED_EN to treat operands and results as two's complement.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OUT_WIDTH  = 24;

`ifdef MVM_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
    typedef logic signed [DEF_DATA_WIDTH-1:0] operand_t;
    typedef logic signed [DEF_OUT_WIDTH-1:0]  acc_t;
`else
    localparam bit SIGNED_EN = 1'b0;
    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;
    typedef logic [DEF_OUT_WIDTH-1:0]  acc_t;
`endif

    // Smallest accumulator that cannot overflow over a full row.
    function automatic int min_out_width(input int data_width, input int cols);
        return 2 * data_width + $clog2(cols);
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: a COLS-deep A-row FIFO feeding a multiply-accumulate.
// Operand signedness follows MVM_SIGNED_EN.
module mvm_mac_lane
    import mvm_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_n,
    input  logic                  run,
    input  logic                  zero_acc,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] b_val,
    output logic [OUT_WIDTH-1:0]  acc,
    output logic                  full_nxt,
    output logic                  wr_err
);

    localparam int PW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW     = $clog2(COLS + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] DEPTH    = CW'(COLS);
    localparam logic [PW-1:0] LAST_PTR = PW'(COLS - 1);

    logic [DATA_WIDTH-1:0] mem_r [COLS];
    logic [PW-1:0]         wp_r;
    logic [PW-1:0]         rp_r;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt;
    logic                  full_s;
    logic                  wr_ok_s;
    logic [PROD_W-1:0]     prod_s;
    logic [OUT_WIDTH-1:0]  prod_ext_s;

    assign full_s   = (cnt_r == DEPTH);
    assign wr_ok_s  = wren && !run && !full_s;
    assign wr_err   = wren && (run || full_s);
    assign full_nxt = (cnt_nxt == DEPTH);

`ifdef MVM_SIGNED_EN
    assign prod_s = $signed(mem_r[rp_r]) * $signed(b_val);
`else
    assign prod_s = mem_r[rp_r] * b_val;
`endif
    assign prod_ext_s = {{(OUT_WIDTH - PROD_W){SIGNED_EN & prod_s[PROD_W-1]}}, prod_s};

    // FIFO occupancy next value; writes and pops never coincide.
    always_comb begin
        cnt_nxt = cnt_r;
        if (!clr_n) begin
            cnt_nxt = '0;
        end else if (wr_ok_s) begin
            cnt_nxt = cnt_r + CW'(1);
        end else if (consume) begin
            cnt_nxt = cnt_r - CW'(1);
        end else begin
            cnt_nxt = cnt_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r  <= '0;
            rp_r  <= '0;
            cnt_r <= '0;
        end else if (!clr_n) begin
            wp_r  <= '0;
            rp_r  <= '0;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt;
            if (wr_ok_s) wp_r <= (wp_r == LAST_PTR) ? '0 : wp_r + PW'(1);
            else         wp_r <= wp_r;
            if (consume) rp_r <= (rp_r == LAST_PTR) ? '0 : rp_r + PW'(1);
            else         rp_r <= rp_r;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (clr_n && wr_ok_s) mem_r[wp_r] <= din;
    end

    // Accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc <= '0;
        else if (!clr_n)    acc <= '0;
        else if (zero_acc)  acc <= '0;
        else if (consume)   acc <= acc + prod_ext_s;
        else                acc <= acc;
    end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: FSM, shared B FIFO and B skew chain feeding ROWS MAC lanes.
// Define MVM_SIGNED_EN for two's complement operation.
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Clr,
    input  logic [ROWS-1:0]       a_wren,
    input  logic [DATA_WIDTH-1:0] a_fifo_in [ROWS],
    input  logic                  b_wren,
    input  logic [DATA_WIDTH-1:0] b_fifo_in,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [OUT_WIDTH-1:0]  out [ROWS]
);

    localparam int PW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FW   = $clog2(COLS + 1);
    localparam int TW   = $clog2(COLS + ROWS + 1);
    localparam logic [FW-1:0] DEPTH    = FW'(COLS);
    localparam logic [PW-1:0] LAST_PTR = PW'(COLS - 1);
    localparam logic [TW-1:0] B_CYCLES = TW'(COLS);
    localparam logic [TW-1:0] LAST_CNT = TW'(COLS + ROWS);

    if (OUT_WIDTH < min_out_width(DATA_WIDTH, COLS)) begin : g_width_check
        $error("mvm_engine: OUT_WIDTH too small for DATA_WIDTH and COLS");
    end

    state_t                state_r, state_nxt;
    logic [TW-1:0]         cnt_r;
    logic [DATA_WIDTH-1:0] b_mem_r [COLS];
    logic [PW-1:0]         b_wp_r, b_rp_r;
    logic [FW-1:0]         b_cnt_r, b_cnt_nxt;
    logic [DATA_WIDTH-1:0] b_chain_r [ROWS];
    logic [ROWS-1:0]       b_vld_r;
    logic [ROWS-1:0]       lane_full_nxt_s;
    logic [ROWS-1:0]       lane_err_s;
    logic                  run_s, start_ok_s, start_err_s;
    logic                  b_full_s, b_wr_ok_s, b_err_s, b_pop_s;
    logic                  busy_nxt, done_nxt, ready_nxt, err_nxt;

    assign run_s       = (state_r == RUN);
    assign start_ok_s  = Clr && start && ready && !run_s;
    assign start_err_s = start && !ready && !run_s;
    assign b_full_s    = (b_cnt_r == DEPTH);
    assign b_wr_ok_s   = b_wren && !run_s && !b_full_s;
    assign b_err_s     = b_wren && (run_s || b_full_s);
    assign b_pop_s     = run_s && (cnt_r < B_CYCLES);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt;
    end

    // Next-state logic; Clr overrides everything.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_ok_s) state_nxt = RUN;
                else            state_nxt = state_r;
            end
            RUN: begin
                if (cnt_r == LAST_CNT) state_nxt = DONE;
                else                   state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
        if (!Clr) state_nxt = IDLE;
        else      state_nxt = state_nxt;
    end

    // Next values of the registered status outputs.
    always_comb begin
        busy_nxt  = (state_nxt == RUN);
        done_nxt  = run_s && (state_nxt == DONE);
        ready_nxt = (state_nxt != RUN) && (&lane_full_nxt_s) && (b_cnt_nxt == DEPTH);
        if (!Clr) err_nxt = 1'b0;
        else      err_nxt = err || (|lane_err_s) || b_err_s || start_err_s;
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            done  <= done_nxt;
            ready <= ready_nxt;
            err   <= err_nxt;
        end
    end

    // RUN cycle counter, restarted whenever a run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_r <= '0;
        else if (!Clr)       cnt_r <= '0;
        else if (start_ok_s) cnt_r <= '0;
        else if (run_s)      cnt_r <= cnt_r + TW'(1);
        else                 cnt_r <= cnt_r;
    end

    // B FIFO occupancy next value.
    always_comb begin
        b_cnt_nxt = b_cnt_r;
        if (!Clr)           b_cnt_nxt = '0;
        else if (b_wr_ok_s) b_cnt_nxt = b_cnt_r + FW'(1);
        else if (b_pop_s)   b_cnt_nxt = b_cnt_r - FW'(1);
        else                b_cnt_nxt = b_cnt_r;
    end

    // B FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_wp_r  <= '0;
            b_rp_r  <= '0;
            b_cnt_r <= '0;
        end else if (!Clr) begin
            b_wp_r  <= '0;
            b_rp_r  <= '0;
            b_cnt_r <= '0;
        end else begin
            b_cnt_r <= b_cnt_nxt;
            if (b_wr_ok_s) b_wp_r <= (b_wp_r == LAST_PTR) ? '0 : b_wp_r + PW'(1);
            else           b_wp_r <= b_wp_r;
            if (b_pop_s)   b_rp_r <= (b_rp_r == LAST_PTR) ? '0 : b_rp_r + PW'(1);
            else           b_rp_r <= b_rp_r;
        end
    end

    // B FIFO storage.
    always_ff @(posedge clk) begin
        if (Clr && b_wr_ok_s) b_mem_r[b_wp_r] <= b_fifo_in;
    end

    // Skew chain: stage r reaches lane r, which therefore lags lane 0 by r cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_vld_r <= '0;
            for (int i = 0; i < ROWS; i++) b_chain_r[i] <= '0;
        end else if (!Clr) begin
            b_vld_r <= '0;
            for (int i = 0; i < ROWS; i++) b_chain_r[i] <= '0;
        end else begin
            b_vld_r[0]   <= b_pop_s;
            b_chain_r[0] <= b_mem_r[b_rp_r];
            for (int i = 1; i < ROWS; i++) begin
                b_vld_r[i]   <= b_vld_r[i-1];
                b_chain_r[i] <= b_chain_r[i-1];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        mvm_mac_lane #(
            .COLS       (COLS),
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_n    (Clr),
            .run      (run_s),
            .zero_acc (start_ok_s),
            .wren     (a_wren[r]),
            .din      (a_fifo_in[r]),
            .consume  (b_vld_r[r]),
            .b_val    (b_chain_r[r]),
            .acc      (out[r]),
            .full_nxt (lane_full_nxt_s[r]),
            .wr_err   (lane_err_s[r])
        );
    end

endmodule

// File: tb/tb_mvm_engine.sv
// Directed self-checking bench for mvm_engine with a result scoreboard.
// Covers both the default unsigned build and MVM_SIGNED_EN.
module tb_mvm_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int OW   = 24;
    localparam int LAT  = COLS + ROWS + 1;

    typedef logic [ROWS-1:0][OW-1:0] res_t;

    logic          clk;
    logic          rst_n;
    logic          Clr;
    logic [ROWS-1:0] a_wren;
    logic [DW-1:0] a_fifo_in [ROWS];
    logic          b_wren;
    logic [DW-1:0] b_fifo_in;
    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [OW-1:0] out [ROWS];

    int   n_cmp;
    int   n_err;
    int   n_done;
    int   am [ROWS][COLS];
    int   bv [COLS];
    res_t sb [$];
    res_t last_exp;

    mvm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Clr       (Clr),
        .a_wren    (a_wren),
        .a_fifo_in (a_fifo_in),
        .b_wren    (b_wren),
        .b_fifo_in (b_fifo_in),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_expected();
        res_t    e;
        longint  acc;
        for (int r = 0; r < ROWS; r++) begin
            acc = 0;
            for (int c = 0; c < COLS; c++) acc += longint'(am[r][c]) * longint'(bv[c]);
            e[r] = acc[OW-1:0];
        end
        sb.push_back(e);
    endtask

    // Writes every A FIFO COLS times and the B FIFO nb times, one element per cycle.
    task automatic load(input int nb);
        for (int c = 0; c < COLS; c++) begin
            @(negedge clk);
            a_wren = '1;
            for (int r = 0; r < ROWS; r++) a_fifo_in[r] = am[r][c][DW-1:0];
            b_wren    = (c < nb);
            b_fifo_in = bv[c][DW-1:0];
        end
        @(negedge clk);
        a_wren = '0;
        b_wren = 1'b0;
    endtask

    task automatic pulse_clr();
        Clr = 1'b0;
        @(negedge clk);
        Clr = 1'b1;
    endtask

    // Starts a run, measures done latency and compares against the scoreboard head.
    task automatic run_check(input string tag);
        int   cyc;
        res_t e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        check({tag, "_ready_off"}, 64'(ready), 64'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        last_exp = e;
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s_out%0d", tag, r), 64'(out[r]), 64'(e[r]));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_err = 0; n_done = 0;
        rst_n = 1'b0; Clr = 1'b1; start = 1'b0;
        a_wren = '0; b_wren = 1'b0; b_fifo_in = '0;
        for (int r = 0; r < ROWS; r++) a_fifo_in[r] = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        for (int r = 0; r < ROWS; r++) check($sformatf("rst_out%0d", r), 64'(out[r]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity matrix, B = 1..8.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < COLS; c++) bv[c] = c + 1;
        load(COLS); push_expected();
        check("ident_ready", 64'(ready), 64'd1);
        run_check("ident");
        check("ident_err", 64'(err), 64'd0);

`ifdef MVM_SIGNED_EN
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = -128;
        for (int c = 0; c < COLS; c++) bv[c] = -128;
        load(COLS); push_expected();
        run_check("neg128");
        check("neg128_out0_val", 64'(out[0]), 64'd131072);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = (r == 0) ? -1 : 1;
        for (int c = 0; c < COLS; c++) bv[c] = 5;
        load(COLS); push_expected();
        run_check("minus1");
        check("minus1_out0_val", 64'(out[0]), 64'hFFFFD8);
`else
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = 255;
        for (int c = 0; c < COLS; c++) bv[c] = 255;
        load(COLS); push_expected();
        run_check("ones");
        check("ones_out7_val", 64'(out[7]), 64'd520200);
`endif
        check("max_err", 64'(err), 64'd0);

        // Ninth write to A FIFO 3 is dropped and flagged.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = r + c;
        for (int c = 0; c < COLS; c++) bv[c] = c + 2;
        load(COLS); push_expected();
        @(negedge clk);
        a_wren = 8'b0000_1000;
        a_fifo_in[3] = 8'd99;
        @(negedge clk);
        a_wren = '0;
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_ready", 64'(ready), 64'd1);
        run_check("ovf");
        check("ovf_err_sticky", 64'(err), 64'd1);
        pulse_clr();
        check("clr_err", 64'(err), 64'd0);
        check("clr_out3", 64'(out[3]), 64'd0);
        check("clr_ready", 64'(ready), 64'd0);

        // Start with only 7 B entries is refused.
        load(COLS - 1);
        check("b7_ready", 64'(ready), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b7_busy", 64'(busy), 64'd0);
        check("b7_err", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        check("b7_still_idle", 64'(busy), 64'd0);
        pulse_clr();

        // Clr four cycles into a run aborts it.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = 1;
        for (int c = 0; c < COLS; c++) bv[c] = 3;
        load(COLS);
        d0 = n_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        pulse_clr();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(ready), 64'd0);
        for (int r = 0; r < ROWS; r++) check($sformatf("abort_out%0d", r), 64'(out[r]), 64'd0);
        repeat (25) @(negedge clk);
        check("abort_no_done", 64'(n_done - d0), 64'd0);

        // Back-to-back runs, second FIFO fill during DONE.
        d0 = n_done;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = (r * 3 + c) % 7;
        for (int c = 0; c < COLS; c++) bv[c] = 9 - c;
        load(COLS); push_expected();
        run_check("b2b_1");
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) am[r][c] = (r + 2 * c) % 11;
        for (int c = 0; c < COLS; c++) bv[c] = 2 * c + 1;
        load(COLS); push_expected();
        check("b2b_hold_out0", 64'(out[0]), 64'(last_exp[0]));
        check("b2b_hold_out5", 64'(out[5]), 64'(last_exp[5]));
        check("b2b_ready_done", 64'(ready), 64'd1);
        run_check("b2b_2");
        check("b2b_done_count", 64'(n_done - d0), 64'd2);
        check("final_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
